// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes,
// instruction field values, ALU operation codes and datapath mux selects.
package mc_pkg;

    // Controller states; the numeric codes are visible on the debug state port.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        FAULT    = 4'd11
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Function field (IR[5:0]) values the controller cares about
    localparam logic [5:0] FN_JR = 6'b001000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;  // ALU decodes funct itself
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_LUI   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    // Destination register select
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    // Writeback source select
    localparam logic [2:0] M2R_ALUOUT = 3'b000;
    localparam logic [2:0] M2R_MDR    = 3'b001;
    localparam logic [2:0] M2R_PC     = 3'b010;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Instruction class dispatch out of DECODE; unknown opcodes trap.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_RTYPE:          nxt = (fn == FN_JR) ? JUMP : EXEC_R;
            OP_LW, OP_SW:      nxt = MEM_ADDR;
            OP_BEQ, OP_BNE:    nxt = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_SLTI, OP_SLTIU, OP_LUI:
                               nxt = EXEC_I;
            OP_J, OP_JAL:      nxt = JUMP;
            default:           nxt = FAULT;
        endcase
        return nxt;
    endfunction

    // ALU operation for immediate-form arithmetic/logic instructions.
    function automatic logic [3:0] exec_i_alu_op(input logic [5:0] op);
        logic [3:0] aop;
        case (op)
            OP_ANDI:  aop = ALU_AND;
            OP_ORI:   aop = ALU_OR;
            OP_XORI:  aop = ALU_XOR;
            OP_SLTI:  aop = ALU_SLT;
            OP_LUI:   aop = ALU_LUI;
            OP_SLTIU: aop = ALU_SLTU;
            default:  aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic uses_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive-wait counter for memory handshakes. Flags expiry in the wait
// cycle that would bring the count up to WAIT_LIMIT, so the FSM can trap on
// the following edge; a ready in that same cycle clears instead of expiring.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive wait cycles; saturate so the value never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = inc && !clear && (cnt == LIMIT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the shared-memory, shared-ALU MIPS
// datapath. Outputs are decoded from the state register; only the FETCH
// load enables and the SW completion pulse also look at mem_ready.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   FETCH     | read instruction at PC, PC+4 into PC when memory is ready
//   DECODE    | dispatch on opcode, precompute branch target into ALUOut
//   EXEC_R    | rs op rt for R-type
//   EXEC_I    | rs op imm for immediate ALU instructions
//   MEM_ADDR  | rs + imm effective address for LW/SW
//   MEM_RD    | data read at ALUOut, wait for ready
//   MEM_WR    | data write at ALUOut, wait for ready, instruction ends
//   WB_ALU    | ALUOut into rd (R-type) or rt (immediate)
//   WB_MEM    | MDR into rt
//   BRANCH    | compare rs/rt, load branch target if taken
//   JUMP      | J/JAL/JR PC load, JAL also links PC+4 into $31
//   FAULT     | trap on illegal opcode or memory timeout, left only by reset
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       imm_src,
    output logic       instr_done,
    output logic       fault
);

    state_t state_q;
    logic   in_wait;
    logic   wait_clear;
    logic   wait_inc;
    logic   wait_expired;

    // Only the three memory-handshake states accumulate wait cycles; every
    // other state (and any ready cycle) holds the counter at zero, which also
    // guarantees it starts from zero on entry to a wait state.
    assign in_wait    = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign wait_inc   = in_wait && !mem_ready;
    assign wait_clear = !in_wait || mem_ready;

    mc_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .inc     (wait_inc),
        .expired (wait_expired)
    );

    // State sequencing; memory states advance on ready, trap on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready)         state_q <= DECODE;
                    else if (wait_expired) state_q <= FAULT;
                end
                DECODE:   state_q <= decode_next(opcode, funct);
                EXEC_R:   state_q <= WB_ALU;
                EXEC_I:   state_q <= WB_ALU;
                MEM_ADDR: state_q <= (opcode == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD: begin
                    if (mem_ready)         state_q <= WB_MEM;
                    else if (wait_expired) state_q <= FAULT;
                end
                MEM_WR: begin
                    if (mem_ready)         state_q <= FETCH;
                    else if (wait_expired) state_q <= FAULT;
                end
                WB_ALU:   state_q <= FETCH;
                WB_MEM:   state_q <= FETCH;
                BRANCH:   state_q <= FETCH;
                JUMP:     state_q <= FETCH;
                FAULT:    state_q <= FAULT;
                default:  state_q <= FAULT;
            endcase
        end
    end

    assign state = state_q;

    // Control decode per state; reset forces every strobe and select low at once.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        imm_src    = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALU;
                    end
                end
                DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    alu_op    = ALU_ADD;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_RT;
                    alu_op    = ALU_FUNCT;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = exec_i_alu_op(opcode);
                    imm_src   = uses_zero_ext(opcode);
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_ADD;
                end
                MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                MEM_WR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                WB_ALU: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_ALUOUT;
                    reg_dst    = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
                    instr_done = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    reg_dst    = REG_DST_RT;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_RT;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_SRC_ALUOUT;
                    pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                    instr_done = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    // Only JR reaches JUMP with an R-type opcode.
                    pc_src     = (opcode == OP_RTYPE) ? PC_SRC_RS : PC_SRC_JUMP;
                    if (opcode == OP_JAL) begin
                        // PC still holds PC+4 here, which is the link value.
                        reg_write  = 1'b1;
                        reg_dst    = REG_DST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
                FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    fault = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// per-instruction result, the monitor accumulates what it sees and compares
// whenever the controller finishes an instruction or traps.
module tb_multicycle_control;

    localparam int LIM = 15;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       imm_src;
    logic       instr_done;
    logic       fault;

    multicycle_control #(.WAIT_LIMIT(LIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .instr_done (instr_done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat;       // cycles from first FETCH cycle to done/trap cycle
        int is_fault;
        int st;        // state in the done cycle
        int pcw;
        int pcs;
        int rw;
        int rd;
        int m2r;
        int n_ir;
        int n_pcw;
        int n_rd;
        int n_wr;
        int n_rw;
        int chk_exec;
        int aop;
        int imm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: instruction class -> cycle count and final-cycle controls.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int wf, input int wm);
        exp_t e;
        int   pre;
        bit   rt, jr, lw, sw, br, jmp, ialu;
        e    = '{default: 0};
        rt   = (op == OP_R) && (fn != 6'h08);
        jr   = (op == OP_R) && (fn == 6'h08);
        lw   = (op == OP_LW);
        sw   = (op == OP_SW);
        br   = (op == OP_BEQ) || (op == OP_BNE);
        jmp  = jr || (op == OP_J) || (op == OP_JAL);
        ialu = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI};
        if (wf >= LIM) begin
            e.is_fault = 1;
            e.lat      = LIM + 1;
            e.n_rd     = LIM;
            return e;
        end
        pre     = wf + 1;
        e.n_ir  = 1;
        e.n_pcw = 1;
        e.n_rd  = pre;
        if (!(rt || jr || lw || sw || br || jmp || ialu)) begin
            e.is_fault = 1;
            e.lat      = pre + 2;
            return e;
        end
        if ((lw || sw) && wm >= LIM) begin
            e.is_fault = 1;
            e.lat      = pre + 2 + LIM + 1;
            if (lw) e.n_rd = pre + LIM;
            else    e.n_wr = LIM;
            return e;
        end
        if (rt || ialu) begin
            e.lat      = pre + 3;
            e.st       = 7;
            e.rw       = 1;
            e.rd       = rt ? 1 : 0;
            e.chk_exec = 1;
            if (rt) e.aop = 2;
            else begin
                case (op)
                    OP_ADDI:  e.aop = 0;
                    OP_ANDI:  e.aop = 3;
                    OP_ORI:   e.aop = 4;
                    OP_XORI:  e.aop = 5;
                    OP_SLTI:  e.aop = 6;
                    OP_LUI:   e.aop = 7;
                    default:  e.aop = 8;
                endcase
                e.imm = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? 1 : 0;
            end
        end else if (lw) begin
            e.lat  = pre + wm + 4;
            e.st   = 8;
            e.rw   = 1;
            e.m2r  = 1;
            e.n_rd = pre + wm + 1;
        end else if (sw) begin
            e.lat  = pre + wm + 3;
            e.st   = 6;
            e.n_wr = wm + 1;
        end else if (br) begin
            e.lat   = pre + 2;
            e.st    = 9;
            e.pcs   = 1;
            e.pcw   = (((op == OP_BEQ) && z) || ((op == OP_BNE) && !z)) ? 1 : 0;
            e.n_pcw = 1 + e.pcw;
        end else begin
            e.lat   = pre + 2;
            e.st    = 10;
            e.pcw   = 1;
            e.n_pcw = 2;
            e.pcs   = jr ? 3 : 2;
            if (op == OP_JAL) begin
                e.rw  = 1;
                e.rd  = 2;
                e.m2r = 2;
            end
        end
        e.n_rw = e.rw;
        return e;
    endfunction

    // Driver: one instruction from its first FETCH cycle; wf/wm are the
    // number of not-ready cycles in FETCH and in the data access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int wf, input int wm);
        exp_t e;
        bit   mem;
        int   ms;
        e = model(op, fn, z, wf, wm);
        sbq.push_back(e);
        mem    = (op == OP_LW) || (op == OP_SW);
        ms     = wf + 3;
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int c = 0; c < e.lat; c++) begin
            if (c < wf)                             mem_ready = 1'b0;
            else if (c == wf)                       mem_ready = 1'b1;
            else if (mem && c >= ms && c < ms + wm) mem_ready = 1'b0;
            else if (mem && c == ms + wm)           mem_ready = 1'b1;
            else                                    mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_fault_then_reset(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (state != 4'd11 || !fault || mem_read || mem_write || pc_write ||
                ir_write || reg_write || instr_done) bad++;
            @(posedge clk);
            #1;
        end
        chk({name, "_fault_held"}, bad, 0);
        reset = 1'b1;
        #1;
        chk({name, "_reset_state"}, int'(state), 0);
        chk({name, "_reset_fault"}, int'(fault), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor state
    int   cyc = 0, m_ir = 0, m_pcw = 0, m_rd = 0, m_wr = 0, m_rw = 0;
    int   ex_seen = 0, ex_aop = 0, ex_imm = 0;
    bit   fault_prev = 1'b0;
    exp_t ev;

    // Accumulate per-instruction observations; compare on done or trap.
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0; m_ir = 0; m_pcw = 0; m_rd = 0; m_wr = 0; m_rw = 0;
            ex_seen = 0;
            fault_prev = 1'b0;
        end else begin
            cyc++;
            m_ir  += int'(ir_write);
            m_pcw += int'(pc_write);
            m_rd  += int'(mem_read);
            m_wr  += int'(mem_write);
            m_rw  += int'(reg_write);
            if (state == 4'd2 || state == 4'd3) begin
                ex_seen = 1;
                ex_aop  = int'(alu_op);
                ex_imm  = int'(imm_src);
            end
            if (instr_done || (fault && !fault_prev)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: state %0d done %0d fault %0d with empty scoreboard",
                             state, instr_done, fault);
                end else begin
                    ev = sbq.pop_front();
                    chk("trap_kind",       int'(fault), ev.is_fault);
                    chk("latency",         cyc,         ev.lat);
                    chk("ir_write_count",  m_ir,        ev.n_ir);
                    chk("pc_write_count",  m_pcw,       ev.n_pcw);
                    chk("mem_read_count",  m_rd,        ev.n_rd);
                    chk("mem_write_count", m_wr,        ev.n_wr);
                    chk("reg_write_count", m_rw,        ev.n_rw);
                    if (ev.is_fault == 0) begin
                        chk("done_state",      int'(state),      ev.st);
                        chk("done_pc_write",   int'(pc_write),   ev.pcw);
                        chk("done_pc_src",     int'(pc_src),     ev.pcs);
                        chk("done_reg_write",  int'(reg_write),  ev.rw);
                        chk("done_reg_dst",    int'(reg_dst),    ev.rd);
                        chk("done_mem_to_reg", int'(mem_to_reg), ev.m2r);
                    end
                    if (ev.chk_exec != 0) begin
                        chk("exec_seen",    ex_seen, 1);
                        chk("exec_alu_op",  ex_aop,  ev.aop);
                        chk("exec_imm_src", ex_imm,  ev.imm);
                    end
                end
                cyc = 0; m_ir = 0; m_pcw = 0; m_rd = 0; m_wr = 0; m_rw = 0;
                ex_seen = 0;
            end
            fault_prev = fault;
            if (cyc > 200) begin
                checks++;
                errors++;
                $display("FAIL monitor_watchdog: no done or trap within 200 cycles, state %0d", state);
                cyc = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         idx;
        int         wf;
        int         wm;
        logic       z;

        reset     = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs_zero",
            int'({pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_src, instr_done, fault}), 0);
        reset = 1'b0;

        // Directed cases
        run_instr(OP_R,     6'h20, 1'b0, 0, 0);   // ADD
        run_instr(OP_LW,    6'h00, 1'b0, 0, 3);   // LW, 3 wait cycles in MEM_RD
        run_instr(OP_BEQ,   6'h00, 1'b1, 0, 0);
        run_instr(OP_BEQ,   6'h00, 1'b0, 0, 0);
        run_instr(OP_BNE,   6'h00, 1'b1, 0, 0);
        run_instr(OP_BNE,   6'h00, 1'b0, 0, 0);
        run_instr(OP_JAL,   6'h00, 1'b0, 0, 0);
        run_instr(OP_R,     6'h08, 1'b0, 0, 0);   // JR
        run_instr(OP_ORI,   6'h00, 1'b0, 0, 0);
        run_instr(OP_SLTIU, 6'h00, 1'b0, 0, 0);
        run_instr(OP_SW,    6'h00, 1'b0, 0, 0);
        run_instr(OP_ADDI,  6'h08, 1'b0, 14, 0);  // ready arrives on the limit cycle
        run_instr(OP_SW,    6'h00, 1'b0, 2, 14);
        run_instr(OP_LW,    6'h00, 1'b0, 1, 14);

        // Randomized legal instruction stream with random wait states
        for (int i = 0; i < 120; i++) begin
            idx = int'($urandom_range(0, 14));
            fn  = 6'($urandom_range(0, 63));
            case (idx)
                0: begin op = OP_R; if (fn == 6'h08) fn = 6'h20; end
                1: begin op = OP_R; fn = 6'h08; end
                2:  op = OP_LW;
                3:  op = OP_SW;
                4:  op = OP_BEQ;
                5:  op = OP_BNE;
                6:  op = OP_J;
                7:  op = OP_JAL;
                8:  op = OP_ADDI;
                9:  op = OP_ANDI;
                10: op = OP_ORI;
                11: op = OP_XORI;
                12: op = OP_SLTI;
                13: op = OP_SLTIU;
                default: op = OP_LUI;
            endcase
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : 0;
            z  = 1'($urandom_range(0, 1));
            run_instr(op, fn, z, wf, wm);
        end

        // Reset in the middle of a store's data access
        opcode    = OP_SW;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sw_in_mem_wr_state", int'(state), 6);
        chk("sw_mem_write_high", int'(mem_write), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_access_mem_write", int'(mem_write), 0);
        chk("reset_mid_access_state", int'(state), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(OP_R, 6'h22, 1'b0, 0, 0);

        // Trap paths
        run_instr(OP_R, 6'h20, 1'b0, LIM, 0);     // FETCH timeout
        hold_fault_then_reset("fetch_timeout");
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0);      // illegal opcode
        hold_fault_then_reset("illegal_opcode");
        run_instr(OP_LW, 6'h00, 1'b0, 0, LIM);    // MEM_RD timeout
        hold_fault_then_reset("mem_rd_timeout");
        run_instr(OP_SW, 6'h00, 1'b0, 3, LIM);    // MEM_WR timeout
        hold_fault_then_reset("mem_wr_timeout");

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencing FSM for the MIPS datapath. It replaces single-cycle decode with a registered state machine. The datapath shares one memory for instruction and data, and one ALU for PC+4, branch target and execute. Each state issues the matching strobes and mux selects. The FSM waits on a memory ready handshake and traps on timeout or on an illegal opcode.

Parameters:
WAIT_LIMIT, 15, maximum consecutive cycles in a memory wait state with mem_ready low before FAULT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
opcode  in  6  IR[31:26]; held stable by the IR after FETCH.
funct  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory has completed the current access this cycle.
state  out  4  current state encoding, for debug and the bench.
pc_write  out  1  PC load enable.
pc_src  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs.
ir_write  out  1  IR load enable.
iord  out  1  memory address select: 0 PC, 1 ALUOut.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
reg_write  out  1  register file write enable.
reg_dst  out  2  destination register select: 00 rt, 01 rd, 10 $31.
mem_to_reg  out  3  writeback source: 000 ALUOut, 001 MDR, 010 PC.
alu_src_a  out  1  ALU A select: 0 PC, 1 rs.
alu_src_b  out  2  ALU B select: 00 rt, 01 constant 4, 10 imm, 11 imm<<2.
alu_op  out  4  ALU operation code.
imm_src  out  1  immediate extension: 0 sign, 1 zero.
instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
fault  out  1  sticky error flag.

Behaviour:
- Reset is async and active-high.
- State register resets to FETCH (0). Wait counter resets to 0.
- While reset is high, every output except state is forced to 0.
- Outputs are a Moore decode of state. opcode, funct and zero are additionally used where listed below.
- Defaults in every state: all strobes 0, all selects 0.
- States and their outputs:
  - FETCH(0): mem_read=1, iord=0, a=0, b=01, alu_op=0000.
    - mem_ready high: ir_write=1, pc_write=1, pc_src=00; next DECODE.
    - mem_ready low: stay in FETCH.
  - DECODE(1): a=0, b=11, alu_op=0000 (branch target computed into ALUOut). Next state by opcode:
    - R-type with funct!=001000: EXEC_R.
    - R-type with funct==001000 (JR): JUMP.
    - LW or SW: MEM_ADDR.
    - BEQ or BNE: BRANCH.
    - ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI: EXEC_I.
    - J or JAL: JUMP.
    - Any other opcode: FAULT.
  - EXEC_R(2): a=1, b=00, alu_op=0010; next WB_ALU with reg_dst=01.
  - EXEC_I(3): a=1, b=10; next WB_ALU with reg_dst=00.
    - alu_op: ADDI 0000, ANDI 0011, ORI 0100, XORI 0101, SLTI 0110, LUI 0111, SLTIU 1000.
    - imm_src=1 for ANDI, ORI and XORI only.
  - MEM_ADDR(4): a=1, b=10, alu_op=0000; next MEM_RD for LW, MEM_WR for SW.
  - MEM_RD(5): iord=1, mem_read=1; wait for mem_ready, then WB_MEM.
  - MEM_WR(6): iord=1, mem_write=1; wait for mem_ready, then FETCH with instr_done=1.
  - WB_ALU(7): reg_write=1, mem_to_reg=000; reg_dst=01 if opcode is R-type, else 00; instr_done=1; next FETCH.
  - WB_MEM(8): reg_write=1, mem_to_reg=001, reg_dst=00; instr_done=1; next FETCH.
  - BRANCH(9): a=1, b=00, alu_op=0001, pc_src=01; pc_write=(BEQ&zero)|(BNE&~zero); instr_done=1; next FETCH.
  - JUMP(10): pc_write=1, instr_done=1; next FETCH.
    - pc_src=11 for JR, else 10.
    - JAL additionally asserts reg_write=1, reg_dst=10, mem_to_reg=010. The PC register still holds PC+4 in this cycle.
  - FAULT(11): fault=1, all strobes 0. Exit only via reset.
- Latency with zero-wait memory, counted in cycles:
  - R-type and I-type ALU instructions: 4.
  - LW: 5.
  - SW: 4.
  - Branch, J, JAL, JR: 3.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR, and on any cycle with mem_ready high.
  - Increments on each wait cycle with mem_ready low.
  - When it reaches WAIT_LIMIT, next state is FAULT.
  - Width is clog2(WAIT_LIMIT+1).
  - mem_ready on the same cycle the limit is reached: ready wins and the access completes.
- Strobes must be glitch-free with respect to state, so pc_write and ir_write in FETCH are combinational only on mem_ready.
- Reset asserted mid-access (e.g. in MEM_WR): mem_write drops immediately. FETCH resumes on the first clk edge after release.

Decomposition:
- Package mc_pkg holds:
  - state localparams, 0 through 11;
  - opcode and funct constants;
  - alu_op codes;
  - pc_src, reg_dst, mem_to_reg and alu_src_b encodings.
- One sub-module, mc_wait_timer: the parameterised wait counter with clear, inc and expired outputs.

Test Plan:
- ADD (opcode 000000, funct 100000), mem_ready always 1 -> state sequence 0,1,2,7. reg_write=1, reg_dst=01 and instr_done=1 in cycle 4 only.
- LW with mem_ready low for 3 cycles in MEM_RD -> state 5 held 4 cycles, then 8 with mem_to_reg=001. 8 cycles total.
- BEQ with zero=1 -> pc_write=1, pc_src=01 in state 9. Repeat with zero=0 -> pc_write=0. BNE gives the inverse results.
- JAL -> state 10 asserts pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=010. JR (funct 001000) -> pc_src=11, reg_write=0.
- Fault paths:
  - mem_ready held low 15 cycles in FETCH -> fault=1, state=11, held for 50 further cycles; reset then returns to state 0.
  - Opcode 111111 -> FAULT directly after DECODE.
- ORI -> imm_src=1, alu_op=0100. SLTIU -> imm_src=0, alu_op=1000. Reset pulsed during MEM_WR -> mem_write=0 in the same cycle, state=0.
